// File: rtl/win_gen_param.sv
// win_gen_param: K x K neighbourhood window fetcher for the median-filter datapath.
// On an accepted start it reads the window around (row, col) from a single-port
// image ROM, one tap per cycle in raster order. It applies zero or replicate
// border handling and then presents the whole window with a one-cycle valid pulse.
//
// Ports:
//   CLK, RSTn         clock, asynchronous active-low reset
//   start             single-cycle request, accepted only in IDLE
//   row, col          1-based centre coordinate
//   rows, cols        image height / width
//   rom_rd, rom_addr  ROM read strobe and address, read data on rom_data after RD_LAT cycles
//   win_data          window taps, tap t at [t*DW +: DW], t=0 is top-left
//   win_valid         one-cycle pulse when win_data is updated
//   busy              high from the cycle after an accepted start through the win_valid cycle
//   err               one-cycle pulse when a start is rejected for bad geometry
module win_gen_param #(
  parameter int DW          = 8,
  parameter int AW          = 18,
  parameter int DIMW        = 10,
  parameter int KSIZE       = 3,
  parameter int RD_LAT      = 2,
  parameter int BORDER_MODE = 0
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        start,
  input  logic [DIMW-1:0]             row,
  input  logic [DIMW-1:0]             col,
  input  logic [DIMW-1:0]             rows,
  input  logic [DIMW-1:0]             cols,
  output logic                        rom_rd,
  output logic [AW-1:0]               rom_addr,
  input  logic [DW-1:0]               rom_data,
  output logic [KSIZE*KSIZE*DW-1:0]   win_data,
  output logic                        win_valid,
  output logic                        busy,
  output logic                        err
);
  localparam int KK = KSIZE * KSIZE;
  localparam int H  = (KSIZE - 1) / 2;
  localparam int KW = $clog2(KK);
  localparam int SW = DIMW + 2;
  localparam int PW = 2 * DIMW;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k_q;
  logic [2:0]      dcnt;
  logic [DIMW-1:0] m_q, n_q, rows_q, cols_q;

  logic            tag_vld_p  [RD_LAT+1];
  logic            tag_zero_p [RD_LAT+1];
  logic [KW-1:0]   tag_idx_p  [RD_LAT+1];
  logic [DW-1:0]   work_q     [KK];

  // Saturate a signed coordinate into [1, hi].
  function automatic logic signed [SW-1:0] clamp_coord(input logic signed [SW-1:0] v,
                                                      input logic [DIMW-1:0] hi);
    logic signed [SW-1:0] hi_s;
    hi_s = $signed({2'b00, hi});
    if (v < SW'(1))
      return SW'(1);
    else if (v > hi_s)
      return hi_s;
    else
      return v;
  endfunction

  // Tap about to be issued at the next edge: tap 0 from the start inputs when
  // idle, otherwise the tap after k_q from the latched request.
  logic [DIMW-1:0]      cm, cn, crows, ccols;
  logic [KW-1:0]        idx;
  int                   dr_i, dc_i;
  logic signed [SW-1:0] r_s, c_s, r_cl, c_cl, r_m1, c_m1;
  logic                 in_rng, nxt_rd, geo_bad;
  logic [PW-1:0]        prod;
  logic [AW-1:0]        nxt_addr;

  always_comb begin
    if (state == IDLE) begin
      cm = row;  cn = col;  crows = rows;  ccols = cols;
      idx = '0;
    end else begin
      cm = m_q;  cn = n_q;  crows = rows_q;  ccols = cols_q;
      idx = k_q + 1'b1;
    end
    dr_i   = int'(idx) / KSIZE - H;
    dc_i   = int'(idx) % KSIZE - H;
    r_s    = $signed({2'b00, cm}) + SW'(dr_i);
    c_s    = $signed({2'b00, cn}) + SW'(dc_i);
    in_rng = (r_s >= SW'(1)) && (r_s <= $signed({2'b00, crows})) &&
             (c_s >= SW'(1)) && (c_s <= $signed({2'b00, ccols}));
    // Clamping is the identity for in-range taps, so one address path serves both modes.
    r_cl     = clamp_coord(r_s, crows);
    c_cl     = clamp_coord(c_s, ccols);
    r_m1     = r_cl - SW'(1);
    c_m1     = c_cl - SW'(1);
    prod     = {{DIMW{1'b0}}, r_m1[DIMW-1:0]} * {{DIMW{1'b0}}, ccols}
             + {{DIMW{1'b0}}, c_m1[DIMW-1:0]};
    nxt_addr = AW'(prod);
    nxt_rd   = in_rng || (BORDER_MODE == 1);
    geo_bad  = (row == '0) || (col == '0) || (row > rows) || (col > cols);
  end

  // Capture stage: the tag at the end of the pipeline lines up with rom_data.
  logic                  cap;
  logic [DW-1:0]         cap_val;
  logic [KK*DW-1:0]      win_nxt;

  always_comb begin
    cap     = tag_vld_p[RD_LAT];
    cap_val = tag_zero_p[RD_LAT] ? '0 : rom_data;
    win_nxt = '0;
    for (int t = 0; t < KK; t++)
      win_nxt[t*DW +: DW] = (cap && tag_idx_p[RD_LAT] == KW'(t)) ? cap_val : work_q[t];
  end

  always_ff @(posedge CLK)
    for (int t = 0; t < KK; t++)
      work_q[t] <= win_nxt[t*DW +: DW];

  // Control, issue stage and output shadow.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      k_q       <= '0;
      dcnt      <= '0;
      m_q       <= '0;
      n_q       <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      win_data  <= '0;
      win_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_vld_p[i]  <= 1'b0;
        tag_zero_p[i] <= 1'b0;
        tag_idx_p[i]  <= '0;
      end
    end else begin
      err          <= 1'b0;
      win_valid    <= 1'b0;
      rom_rd       <= 1'b0;
      tag_vld_p[0] <= 1'b0;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_vld_p[i]  <= tag_vld_p[i-1];
        tag_zero_p[i] <= tag_zero_p[i-1];
        tag_idx_p[i]  <= tag_idx_p[i-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (geo_bad) begin
              err <= 1'b1;
            end else begin
              m_q    <= row;
              n_q    <= col;
              rows_q <= rows;
              cols_q <= cols;
              k_q    <= '0;
              busy   <= 1'b1;
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          if (k_q == KW'(KK - 1)) begin
            dcnt  <= '0;
            state <= DRAIN;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == 3'(RD_LAT - 1)) begin
            win_data  <= win_nxt;
            win_valid <= 1'b1;
            state     <= DONE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Issue the next tap when a fetch starts or continues.
      if ((state == IDLE && start && !geo_bad) || (state == FETCH && k_q != KW'(KK - 1))) begin
        rom_rd        <= nxt_rd;
        if (nxt_rd)
          rom_addr    <= nxt_addr;
        tag_vld_p[0]  <= 1'b1;
        tag_zero_p[0] <= !nxt_rd;
        tag_idx_p[0]  <= idx;
      end
    end
  end

endmodule
